inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Instruction fetch stage of the pipelined CPU: owns the program counter, drives the word-addressed instruction-memory port, and consumes the returned instruction into the IF/ID pipeline register. The instruction memory has a 1-cycle registered read with read enable, and the PC advances by 1 per instruction. The block sits between the instruction memory and the decode stage, and takes stall and redirect requests from the hazard unit and the execute stage.

## Interface
- N, 32, width of PC and instruction-memory word address
- W, 32, instruction width
- RESET_PC, 0, word address fetched first after reset
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- i_stall  in  1  decode cannot accept; freeze fetch and IF/ID
- i_redirect  in  1  taken branch or jump; discard wrong-path work
- i_target  in  N  redirect word address, valid with i_redirect
- o_imem_addr  out  N  memory word address (= pc_q)
- o_imem_en  out  1  memory read enable (= ~i_stall | i_redirect)
- i_imem_data  in  W  memory data for the address accepted on the previous enabled edge
- o_inst  out  W  IF/ID instruction
- o_pc  out  N  IF/ID word address of o_inst
- o_valid  out  1  IF/ID holds a real instruction

## Operation
- Registers: pc_q, req_pc, req_valid, and the IF/ID triple {o_inst, o_pc, o_valid}.
- Reset values:
  - pc_q = RESET_PC, req_pc = 0, req_valid = 0
  - o_inst = NOP (0x00000013), o_pc = 0, o_valid = 0
  - state = BOOT
- States:
  - BOOT: no request in flight. The next edge issues pc_q and goes to RUN, or to HOLD if i_stall is high.
  - RUN: a request is in flight and advancing.
  - HOLD: i_stall is high. Next state is RUN when i_stall is low, BOOT on i_redirect.
- Normal edge (no redirect, no stall):
  - req_pc <= pc_q, req_valid <= 1, pc_q <= pc_q + 1
  - IF/ID <= {i_imem_data, req_pc, req_valid}
- Stall edge:
  - pc_q, req_*, and IF/ID hold.
  - o_imem_en = 0, so the memory output also holds. No instruction is lost or duplicated.
- Redirect edge:
  - pc_q <= i_target, req_valid <= 0, o_valid <= 0, o_inst <= NOP, state <= BOOT.
- Priority: rst > i_redirect > i_stall. A redirect during a stall flushes IF/ID and ignores the stall.
- Arithmetic: pc_q + 1 is N-bit modulo, so 2^N-1 wraps to 0 with no flag.
- When o_valid = 0, o_inst is always NOP.

## Timing
- Latency: an address issued at edge k reaches IF/ID at edge k+1 and is visible in the cycle after k+1.
- After rst deasserts:
  - edge 1 issues RESET_PC
  - edge 2 sets o_valid = 1 with o_pc = RESET_PC
- Redirect penalty: the target instruction reaches IF/ID 2 edges after the redirect edge, with one bubble in between.
- Throughput: 1 instruction per cycle when not stalled.
- i_stall may stay high indefinitely. The output is stable for the whole stall.
- rst mid-stall or mid-redirect returns every register to its reset value on that edge.

## Configuration
- FETCH_PERF_CNT_EN defined: adds two outputs.
  - o_fetch_cnt (out, 32): increments on each edge that loads o_valid = 1 into IF/ID.
  - o_stall_cnt (out, 32): increments on each edge with i_stall = 1 and i_redirect = 0.
  - Both clear on rst and wrap modulo 2^32.
- Not defined: the ports and counters are absent, and the remaining behaviour is identical.

## Structure
- Shared package fetch_pkg holds the NOP constant, the RESET_PC default, and the state encoding (BOOT, RUN, HOLD).
- One sub-module, fetch_perf_cnt, holds the two counters. It is instantiated only under FETCH_PERF_CNT_EN.

## Test plan
- Reset then free run, RESET_PC = 0, mem[i] = 0x100 + i:
  - o_valid rises at edge 2 with o_pc = 0, o_inst = 0x100.
  - Following cycles give o_pc = 1, 2, 3 with o_inst = 0x101, 0x102, 0x103.
- Stall for 3 cycles while o_pc = 5:
  - o_pc = 5 and o_inst = 0x105 hold for 3 cycles, and o_imem_en = 0.
  - After release the sequence continues 6, 7 with no gap or duplicate.
- Redirect to 0x40 while o_pc = 8:
  - Next cycle o_valid = 0 with o_inst = NOP.
  - Then o_pc = 0x40 with o_inst = mem[0x40].
- Redirect to 0x20 together with i_stall = 1:
  - The redirect wins and o_valid drops.
  - Once the stall releases, 0x20 is delivered first.
- Wrap with N = 4 and RESET_PC = 14: o_pc sequence is 14, 15, 0, 1.
- With FETCH_PERF_CNT_EN, 10 run cycles and 4 stall cycles after boot: o_fetch_cnt = 9 (first delivery at edge 2), o_stall_cnt = 4.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage.
package fetch_pkg;
  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;
endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus: hazard/execute controls, instruction-memory port, IF/ID outputs.
interface inst_fetch_unit_if #(
  parameter int N = 32,
  parameter int W = 32
);
  logic         i_stall;
  logic         i_redirect;
  logic [N-1:0] i_target;
  logic [N-1:0] o_imem_addr;
  logic         o_imem_en;
  logic [W-1:0] i_imem_data;
  logic [W-1:0] o_inst;
  logic [N-1:0] o_pc;
  logic         o_valid;

  modport master (
    input  i_stall, i_redirect, i_target, i_imem_data,
    output o_imem_addr, o_imem_en, o_inst, o_pc, o_valid
  );

  modport slave (
    output i_stall, i_redirect, i_target, i_imem_data,
    input  o_imem_addr, o_imem_en, o_inst, o_pc, o_valid
  );
endinterface

// File: rtl/fetch_perf_cnt.sv
// Fetch and stall event counters; both wrap modulo 2^32 and clear on rst.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fetch_inc) fetch_cnt <= fetch_cnt + 32'd1;
      if (stall_inc) stall_cnt <= stall_cnt + 32'd1;
    end
  end
endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, 1-cycle registered imem read, IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch/stall performance counters.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int           N        = 32,
  parameter int           W        = 32,
  parameter logic [N-1:0] RESET_PC = N'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        o_fetch_cnt,
  output logic [31:0]        o_stall_cnt
`endif
);
  state_e       state_q, state_d;
  logic [N-1:0] pc_q;
  logic [N-1:0] req_pc;
  logic         req_valid;
  logic [W-1:0] inst_q;
  logic [N-1:0] if_pc_q;
  logic         if_valid_q;

  assign bus.o_imem_addr = pc_q;
  assign bus.o_imem_en   = ~bus.i_stall | bus.i_redirect;
  assign bus.o_inst      = inst_q;
  assign bus.o_pc        = if_pc_q;
  assign bus.o_valid     = if_valid_q;

  // Memory output is frozen by o_imem_en during a stall, so holding req_* keeps
  // i_imem_data paired with req_pc across any stall length.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc     <= '0;
      req_valid  <= 1'b0;
      inst_q     <= W'(NOP);
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
    end else if (bus.i_redirect) begin
      pc_q       <= bus.i_target;
      req_valid  <= 1'b0;
      inst_q     <= W'(NOP);
      if_valid_q <= 1'b0;
    end else if (!bus.i_stall) begin
      req_pc     <= pc_q;
      req_valid  <= 1'b1;
      pc_q       <= pc_q + N'(1);
      inst_q     <= req_valid ? bus.i_imem_data : W'(NOP);
      if_pc_q    <= req_pc;
      if_valid_q <= req_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = bus.i_stall ? HOLD : RUN;
      RUN:     state_d = bus.i_stall ? HOLD : RUN;
      HOLD:    state_d = bus.i_stall ? HOLD : RUN;
      default: state_d = BOOT;
    endcase
    if (bus.i_redirect) state_d = BOOT;
  end

`ifdef FETCH_PERF_CNT_EN
  logic fetch_inc, stall_inc;
  assign fetch_inc = ~bus.i_redirect & ~bus.i_stall & req_valid;
  assign stall_inc = bus.i_stall & ~bus.i_redirect;

  fetch_perf_cnt u_perf (
    .clk       (clk),
    .rst       (rst),
    .fetch_inc (fetch_inc),
    .stall_inc (stall_inc),
    .fetch_cnt (o_fetch_cnt),
    .stall_cnt (o_stall_cnt)
  );
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: main N=32 instance plus an N=4 wrap instance.
module tb_inst_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_w = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  inst_fetch_unit_if #(.N(32), .W(32)) b ();
  inst_fetch_unit_if #(.N(4),  .W(32)) bw ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, fetch_cnt_w, stall_cnt_w;
`endif

  inst_fetch_unit #(.N(32), .W(32), .RESET_PC(32'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_fetch_cnt (fetch_cnt),
    .o_stall_cnt (stall_cnt)
`endif
  );

  inst_fetch_unit #(.N(4), .W(32), .RESET_PC(4'd14)) dut_w (
    .clk (clk),
    .rst (rst_w),
    .bus (bw)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_fetch_cnt (fetch_cnt_w),
    .o_stall_cnt (stall_cnt_w)
`endif
  );

  // Instruction memory model: mem[a] = 0x100 + a, registered read with enable
  always @(posedge clk) if (b.o_imem_en)  b.i_imem_data  <= 32'h100 + b.o_imem_addr;
  always @(posedge clk) if (bw.o_imem_en) bw.i_imem_data <= 32'h100 + 32'(bw.o_imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b.i_stall = 1'b0; b.i_redirect = 1'b0; b.i_target = '0;
    bw.i_stall = 1'b0; bw.i_redirect = 1'b0; bw.i_target = '0;
    rst = 1'b1;
    step(); step();
    total_cnt++; if (b.o_valid !== 1'b0) $display("FAIL reset_valid actual=%0b expected=0", b.o_valid); else pass_cnt++;
    total_cnt++; if (b.o_inst !== NOP) $display("FAIL reset_inst actual=%h expected=%h", b.o_inst, NOP); else pass_cnt++;
    total_cnt++; if (b.o_pc !== 32'd0) $display("FAIL reset_pc actual=%h expected=0", b.o_pc); else pass_cnt++;
    total_cnt++; if (b.o_imem_addr !== 32'd0) $display("FAIL reset_addr actual=%h expected=0", b.o_imem_addr); else pass_cnt++;
    total_cnt++; if (b.o_imem_en !== 1'b1) $display("FAIL reset_en actual=%0b expected=1", b.o_imem_en); else pass_cnt++;
    rst = 1'b0;
    step();  // edge 1: RESET_PC issued
    total_cnt++; if (b.o_valid !== 1'b0 || b.o_inst !== NOP) $display("FAIL edge1_bubble actual=%0b/%h expected=0/%h", b.o_valid, b.o_inst, NOP); else pass_cnt++;
    total_cnt++; if (b.o_imem_addr !== 32'd1) $display("FAIL edge1_addr actual=%h expected=1", b.o_imem_addr); else pass_cnt++;
  endtask

  task automatic test_free_run();
    step();  // edge 2: first delivery
    total_cnt++; if (b.o_valid !== 1'b1 || b.o_pc !== 32'd0 || b.o_inst !== 32'h100)
      $display("FAIL first_fetch actual=%0b/%h/%h expected=1/0/100", b.o_valid, b.o_pc, b.o_inst); else pass_cnt++;
    for (int i = 1; i <= 5; i++) begin
      step();
      total_cnt++; if (b.o_valid !== 1'b1 || b.o_pc !== 32'(i) || b.o_inst !== 32'h100 + 32'(i))
        $display("FAIL run_%0d actual=%0b/%h/%h expected=1/%h/%h", i, b.o_valid, b.o_pc, b.o_inst, i, 32'h100 + 32'(i));
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    b.i_stall = 1'b1;
    #1;
    total_cnt++; if (b.o_imem_en !== 1'b0) $display("FAIL stall_en actual=%0b expected=0", b.o_imem_en); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (b.o_valid !== 1'b1 || b.o_pc !== 32'd5 || b.o_inst !== 32'h105 || b.o_imem_en !== 1'b0)
        $display("FAIL stall_hold_%0d actual=%0b/%h/%h en=%0b expected=1/5/105 en=0", i, b.o_valid, b.o_pc, b.o_inst, b.o_imem_en);
      else pass_cnt++;
    end
    b.i_stall = 1'b0;
    for (int i = 6; i <= 8; i++) begin
      step();
      total_cnt++; if (b.o_valid !== 1'b1 || b.o_pc !== 32'(i) || b.o_inst !== 32'h100 + 32'(i))
        $display("FAIL stall_resume_%0d actual=%0b/%h/%h expected=1/%h/%h", i, b.o_valid, b.o_pc, b.o_inst, i, 32'h100 + 32'(i));
      else pass_cnt++;
    end
  endtask

  task automatic test_redirect();
    b.i_redirect = 1'b1; b.i_target = 32'h40;
    step();
    b.i_redirect = 1'b0;
    total_cnt++; if (b.o_valid !== 1'b0 || b.o_inst !== NOP) $display("FAIL redir_flush actual=%0b/%h expected=0/%h", b.o_valid, b.o_inst, NOP); else pass_cnt++;
    step();
    total_cnt++; if (b.o_valid !== 1'b0 || b.o_inst !== NOP) $display("FAIL redir_bubble actual=%0b/%h expected=0/%h", b.o_valid, b.o_inst, NOP); else pass_cnt++;
    step();
    total_cnt++; if (b.o_valid !== 1'b1 || b.o_pc !== 32'h40 || b.o_inst !== 32'h140)
      $display("FAIL redir_target actual=%0b/%h/%h expected=1/40/140", b.o_valid, b.o_pc, b.o_inst); else pass_cnt++;
    step();
    total_cnt++; if (b.o_pc !== 32'h41 || b.o_inst !== 32'h141) $display("FAIL redir_next actual=%h/%h expected=41/141", b.o_pc, b.o_inst); else pass_cnt++;
  endtask

  task automatic test_redirect_stall();
    b.i_stall = 1'b1; b.i_redirect = 1'b1; b.i_target = 32'h20;
    step();
    b.i_redirect = 1'b0;
    total_cnt++; if (b.o_valid !== 1'b0 || b.o_inst !== NOP) $display("FAIL rs_flush actual=%0b/%h expected=0/%h", b.o_valid, b.o_inst, NOP); else pass_cnt++;
    step(); step();
    total_cnt++; if (b.o_valid !== 1'b0 || b.o_imem_addr !== 32'h20 || b.o_imem_en !== 1'b0)
      $display("FAIL rs_hold actual=%0b/%h en=%0b expected=0/20 en=0", b.o_valid, b.o_imem_addr, b.o_imem_en); else pass_cnt++;
    b.i_stall = 1'b0;
    step();
    total_cnt++; if (b.o_valid !== 1'b0) $display("FAIL rs_bubble actual=%0b expected=0", b.o_valid); else pass_cnt++;
    step();
    total_cnt++; if (b.o_valid !== 1'b1 || b.o_pc !== 32'h20 || b.o_inst !== 32'h120)
      $display("FAIL rs_target actual=%0b/%h/%h expected=1/20/120", b.o_valid, b.o_pc, b.o_inst); else pass_cnt++;
    step();
    total_cnt++; if (b.o_pc !== 32'h21 || b.o_inst !== 32'h121) $display("FAIL rs_next actual=%h/%h expected=21/121", b.o_pc, b.o_inst); else pass_cnt++;
  endtask

  task automatic test_reset_mid_stall();
    b.i_stall = 1'b1; rst = 1'b1;
    step();
    total_cnt++; if (b.o_valid !== 1'b0 || b.o_pc !== 32'd0 || b.o_imem_addr !== 32'd0 || b.o_inst !== NOP)
      $display("FAIL rst_mid_stall actual=%0b/%h/%h/%h expected=0/0/0/%h", b.o_valid, b.o_pc, b.o_imem_addr, b.o_inst, NOP);
    else pass_cnt++;
`ifdef FETCH_PERF_CNT_EN
    total_cnt++; if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0)
      $display("FAIL perf_reset actual=%0d/%0d expected=0/0", fetch_cnt, stall_cnt); else pass_cnt++;
`endif
    rst = 1'b0; b.i_stall = 1'b0;
  endtask

  task automatic test_perf();
    for (int i = 0; i < 10; i++) step();
    total_cnt++; if (b.o_valid !== 1'b1 || b.o_pc !== 32'd8) $display("FAIL perf_run_pc actual=%0b/%h expected=1/8", b.o_valid, b.o_pc); else pass_cnt++;
`ifdef FETCH_PERF_CNT_EN
    total_cnt++; if (fetch_cnt !== 32'd9 || stall_cnt !== 32'd0)
      $display("FAIL perf_run actual=%0d/%0d expected=9/0", fetch_cnt, stall_cnt); else pass_cnt++;
`endif
    b.i_stall = 1'b1;
    for (int i = 0; i < 4; i++) step();
    b.i_stall = 1'b0;
    total_cnt++; if (b.o_pc !== 32'd8) $display("FAIL perf_stall_pc actual=%h expected=8", b.o_pc); else pass_cnt++;
`ifdef FETCH_PERF_CNT_EN
    total_cnt++; if (fetch_cnt !== 32'd9 || stall_cnt !== 32'd4)
      $display("FAIL perf_stall actual=%0d/%0d expected=9/4", fetch_cnt, stall_cnt); else pass_cnt++;
`endif
  endtask

  task automatic test_wrap();
    logic [3:0] exp_pc [4];
    exp_pc[0] = 4'd14; exp_pc[1] = 4'd15; exp_pc[2] = 4'd0; exp_pc[3] = 4'd1;
    rst_w = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++; if (bw.o_valid !== 1'b1 || bw.o_pc !== exp_pc[i] || bw.o_inst !== 32'h100 + 32'(exp_pc[i]))
        $display("FAIL wrap_%0d actual=%0b/%h/%h expected=1/%h/%h", i, bw.o_valid, bw.o_pc, bw.o_inst, exp_pc[i], 32'h100 + 32'(exp_pc[i]));
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_reset_mid_stall();
    test_perf();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
